// File: rtl/pool_relu_buffer.sv
// pool_relu_buffer: ReLU + max-pooling of MAC results into a small read FIFO.
module pool_relu_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int POOL_WIDTH = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  result_ready,
  input  logic [DATA_WIDTH-1:0] mult_add_result,
  input  logic                  relu_en,
  input  logic [POOL_WIDTH-1:0] pool_size,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  overflow
);
  // Maps float16 onto an unsigned scale so max-pooling is a plain compare.
  function automatic logic [DATA_WIDTH-1:0] key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : x | {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction
  logic [POOL_WIDTH-1:0] cnt, win_size, cur_win;
  logic [DATA_WIDTH-1:0] run_max, v, cand;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic last, push, pop, wr;
  always_comb begin
    v          = (relu_en && mult_add_result[DATA_WIDTH-1]) ? '0 : mult_add_result;
    cur_win    = (cnt == '0) ? ((pool_size == '0) ? POOL_WIDTH'(1) : pool_size) : win_size;
    cand       = (cnt == '0 || key(v) > key(run_max)) ? v : run_max;
    last       = cnt == cur_win - POOL_WIDTH'(1);
    fifo_empty = fifo_count == '0;
    fifo_full  = fifo_count == (ADDR_WIDTH+1)'(FIFO_DEPTH);
    push       = result_ready && last;
    pop        = rd_en && !fifo_empty;
    wr         = push && (!fifo_full || pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      win_size   <= '0;
      run_max    <= '0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      rd_valid   <= pop;
      fifo_count <= fifo_count + (ADDR_WIDTH+1)'(wr) - (ADDR_WIDTH+1)'(pop);
      if (pop) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      if (wr) wptr <= wptr + 1'b1;
      if (push && !wr) overflow <= 1'b1;
      if (result_ready) begin
        win_size <= cur_win;
        cnt      <= last ? '0 : cnt + 1'b1;
        if (!last) run_max <= cand;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= cand;
  end
endmodule

// File: tb/tb_pool_relu_buffer.sv
// tb_pool_relu_buffer: directed stimulus, queue-based reference model, per-cycle compare.
module tb_pool_relu_buffer;
  logic clk = 0, rst = 1, rr = 0, relu = 0, rd_en = 0;
  logic [15:0] din = 0;
  logic [3:0] ps = 0;
  logic [15:0] rd_data;
  logic rd_valid, fifo_empty, fifo_full, overflow;
  logic [3:0] fifo_count;
  int checks = 0, errors = 0;
  bit chk_on = 0;

  pool_relu_buffer dut (
    .clk(clk), .rst(rst), .result_ready(rr), .mult_add_result(din), .relu_en(relu),
    .pool_size(ps), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  // Float ordering by sign and magnitude: positives beat negatives, then magnitude decides.
  function automatic bit greater(logic [15:0] a, logic [15:0] b);
    if (a[15] != b[15]) return !a[15];
    return a[15] ? (a[14:0] < b[14:0]) : (a[14:0] > b[14:0]);
  endfunction

  logic [15:0] q[$], win[$];
  logic [15:0] m_data, mv, mx;
  bit m_valid, m_ovf, fp, p;
  int wsz;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete(); win.delete();
      m_data = 0; m_valid = 0; m_ovf = 0; wsz = 1;
    end else begin
      fp = q.size() == 8;
      p = rd_en && q.size() != 0;
      m_valid = p;
      if (p) m_data = q.pop_front();
      if (rr) begin
        mv = (relu && din[15]) ? 16'h0000 : din;
        if (win.size() == 0) wsz = (ps == 0) ? 1 : int'(ps);
        win.push_back(mv);
        if (win.size() == wsz) begin
          mx = win[0];
          foreach (win[i]) if (greater(win[i], mx)) mx = win[i];
          win.delete();
          if (!fp || p) q.push_back(mx);
          else m_ovf = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("rd_data", rd_data, m_data);
      chk("rd_valid", 16'(rd_valid), 16'(m_valid));
      chk("fifo_count", 16'(fifo_count), 16'(q.size()));
      chk("fifo_empty", 16'(fifo_empty), 16'(q.size() == 0));
      chk("fifo_full", 16'(fifo_full), 16'(q.size() == 8));
      chk("overflow", 16'(overflow), 16'(m_ovf));
    end
  end

  task automatic smp(input logic [15:0] d, input logic [3:0] s, input logic r);
    @(negedge clk);
    rr = 1; din = d; ps = s; relu = r; rd_en = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    rr = 0; rd_en = 0;
  endtask

  task automatic pop(input logic [15:0] e);
    @(negedge clk);
    rr = 0; rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    chk("pop_valid", 16'(rd_valid), 16'h1);
    chk("pop_data", rd_data, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rr = 0; rd_en = 0; rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk_on = 1;
    chk("rst_count", 16'(fifo_count), 16'h0);
    chk("rst_empty", 16'(fifo_empty), 16'h1);
    chk("rst_valid", 16'(rd_valid), 16'h0);
    rst = 1;
    // pool of 4 with ReLU
    smp(16'h4000, 4, 1); smp(16'h4600, 4, 1); smp(16'h4a00, 4, 1); smp(16'h4b00, 4, 1);
    idle();
    chk("pool4_count", 16'(fifo_count), 16'h1);
    pop(16'h4b00);
    idle();
    chk("valid_drop", 16'(rd_valid), 16'h0);
    // ReLU on/off and signed zeros
    smp(16'hc000, 2, 1); smp(16'hbc00, 2, 1); pop(16'h0000);
    smp(16'hc000, 2, 0); smp(16'hbc00, 2, 0); pop(16'hbc00);
    smp(16'h8000, 2, 0); smp(16'h0000, 2, 0); pop(16'h0000);
    // overflow with nine singleton windows
    for (int i = 0; i < 9; i++) smp(16'h3c00 + 16'(i * 'h200), 1, 0);
    idle();
    chk("ovf_full", 16'(fifo_full), 16'h1);
    chk("ovf_count", 16'(fifo_count), 16'h8);
    chk("ovf_flag", 16'(overflow), 16'h1);
    for (int i = 0; i < 8; i++) pop(16'h3c00 + 16'(i * 'h200));
    chk("drain_empty", 16'(fifo_empty), 16'h1);
    @(negedge clk); rd_en = 1;
    @(negedge clk); rd_en = 0;
    chk("empty_rd_valid", 16'(rd_valid), 16'h0);
    chk("empty_rd_hold", rd_data, 16'h4a00);
    // simultaneous push and pop while full
    do_reset();
    for (int i = 0; i < 8; i++) smp(16'h1000 + 16'(i), 1, 0);
    @(negedge clk);
    rr = 1; din = 16'h2000; ps = 1; rd_en = 1;
    @(negedge clk);
    rr = 0; rd_en = 0;
    chk("pp_count", 16'(fifo_count), 16'h8);
    chk("pp_ovf", 16'(overflow), 16'h0);
    chk("pp_data", rd_data, 16'h1000);
    for (int i = 1; i < 8; i++) pop(16'h1000 + 16'(i));
    pop(16'h2000);
    // asynchronous reset mid-window
    smp(16'h4a00, 4, 0); smp(16'h4000, 4, 0);
    @(negedge clk);
    rr = 0;
    #2 rst = 0;
    #1;
    chk("arst_data", rd_data, 16'h0);
    chk("arst_count", 16'(fifo_count), 16'h0);
    chk("arst_empty", 16'(fifo_empty), 16'h1);
    @(negedge clk);
    rst = 1;
    smp(16'h3c00, 4, 0); smp(16'h4000, 4, 0); smp(16'h3800, 4, 0); smp(16'h3c00, 4, 0);
    idle();
    chk("arst_win_count", 16'(fifo_count), 16'h1);
    pop(16'h4000);
    // pool_size 0, mid-window change, NaN ordering
    smp(16'h1234, 0, 0); pop(16'h1234);
    smp(16'h3c00, 2, 0); smp(16'h4000, 3, 0);
    idle();
    chk("chg_count", 16'(fifo_count), 16'h1);
    pop(16'h4000);
    smp(16'h3800, 3, 0); smp(16'h3000, 3, 0); smp(16'h3400, 3, 0); pop(16'h3800);
    smp(16'h7c00, 2, 0); smp(16'h7e00, 2, 0); pop(16'h7e00);
    idle(); idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pool_relu_buffer.md
# pool_relu_buffer

Downstream stage of the float16 multiply-accumulate unit in the conv datapath. It captures each finished accumulation on the MAC's `result_ready`/`mult_add_result` outputs and applies optional ReLU. It max-pools a programmable number of consecutive results and queues each pooled value in a small FIFO, from which the output write-back logic reads.

## Interface
- `DATA_WIDTH`, 16: float16 word width; fixed at 16.
- `POOL_WIDTH`, 4: width of `pool_size`.
- `FIFO_DEPTH`, 8: number of FIFO entries; must be a power of two.
- `ADDR_WIDTH`, 3: log2(`FIFO_DEPTH`).
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (0: reset; 1: run).
- `result_ready`  input  1  MAC result valid; each high cycle is one result.
- `mult_add_result`  input  DATA_WIDTH  float16 MAC result.
- `relu_en`  input  1  1: apply ReLU before pooling.
- `pool_size`  input  POOL_WIDTH  results per pooling window; 0 is treated as 1.
- `rd_en`  input  1  pop request from the consumer.
- `rd_data`  output  DATA_WIDTH  popped pooled value, registered.
- `rd_valid`  output  1  one-cycle pulse; `rd_data` is updated this cycle.
- `fifo_empty`  output  1  no entries are stored.
- `fifo_full`  output  1  `FIFO_DEPTH` entries are stored.
- `fifo_count`  output  ADDR_WIDTH+1  number of stored entries.
- `overflow`  output  1  sticky flag; a pooled value was dropped.

## Operation
- **ReLU.** When `relu_en`=1 and sign bit [15]=1, the value becomes 16'h0000. This includes -0, -inf and negative NaN. All other values pass unchanged.
- **Ordering key.** For a value x: if sign=1, key = ~x; otherwise key = x | 16'h8000. Larger unsigned key means a larger value.
  - Consequences: -0 < +0, and positive NaN > +inf.
  - This ordering is decided; do not special-case NaN.
- **Window state.** Counter `cnt` (POOL_WIDTH bits), register `run_max` (16 bits), and `win_size` latched from `pool_size` (0 mapped to 1).
- **Per sample** (`result_ready`=1), with v = the ReLU output:
  - If `cnt`=0, latch `win_size` and use v as the candidate.
  - Otherwise the candidate is whichever of v and `run_max` has the larger key. On equal keys, keep `run_max`.
  - If `cnt` = `win_size`-1: push the candidate and set `cnt` to 0.
  - Otherwise: `run_max` takes the candidate and `cnt` increments.
- **`pool_size` changes** take effect only at the next window start.
- **FIFO storage.** Circular buffer with read and write pointers of ADDR_WIDTH bits that wrap modulo `FIFO_DEPTH`, plus an occupancy counter.
- **Push.** Writes `mem[wptr]` and increments `wptr` when not full, or when full and a pop happens the same cycle.
  - When full with no pop, the value is dropped, `overflow` is set, and the pointers do not change.
- **Pop** (`rd_en`=1 and not empty):
  - `rd_data` <= `mem[rptr]`, `rptr` increments, `rd_valid`=1 for that cycle.
  - `rd_en` while empty is ignored: `rd_data` holds and `rd_valid`=0.
- **Simultaneous push and pop.** Both execute and `fifo_count` is unchanged, including when full. The popped value is the oldest entry, never the one being pushed.
- **Flags.** `fifo_empty` = (count==0) and `fifo_full` = (count==`FIFO_DEPTH`), both derived from the registered count.
- **`overflow`** clears only on reset.

## Timing
- **Reset** (`rst`=0, asynchronous): `rd_data`=0, `rd_valid`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, `cnt`=0, `run_max`=0, pointers=0.
  - FIFO memory contents are don't-care.
- **Reset mid-window:** the partial window is discarded. The first sample after release starts a new window.
- **Push latency:** the window-completing sample, presented with `result_ready` at rising edge E, is stored at edge E. `fifo_count` and `fifo_empty` reflect it after E.
- **Pop latency:** with `rd_en` high at edge E, `rd_data` and `rd_valid` are valid after E, and `rd_valid` drops after E+1 unless `rd_en` is repeated.
- **Throughput:** one sample per cycle and one pop per cycle, sustained.
- **Back-to-back samples:** the MAC may assert `result_ready` on consecutive cycles; no samples may be lost.

## Test plan
- **Pool of 4, ReLU on:** samples 0x4000, 0x4600, 0x4a00, 0x4b00, with ReLU on and `pool_size`=4 -> one entry, `fifo_count`=1. Pop gives `rd_data`=0x4b00 with a one-cycle `rd_valid`.
- **ReLU on/off:** `pool_size`=2, samples 0xc000, 0xbc00.
  - With `relu_en`=1 -> pops 0x0000.
  - With `relu_en`=0 -> pops 0xbc00.
  - Then 0x8000 (-0), 0x0000 (+0) with `relu_en`=0 -> pops 0x0000.
- **Overflow:** `pool_size`=1, nine distinct samples 0x3c00..0x4c00 with no reads -> `fifo_full`=1, `fifo_count`=8, `overflow`=1. Eight pops return the first eight samples in order, then `fifo_empty`=1; a further `rd_en` gives no `rd_valid`.
- **Push and pop when full:** fill to 8, then a completing sample plus `rd_en` in the same cycle -> the oldest entry is popped, the new value is stored, `fifo_count` stays 8 and `overflow` stays 0. Pointer wrap is verified by draining.
- **Reset mid-window:** `pool_size`=4 with two samples (0x4a00, 0x4000), then `rst` pulsed low asynchronously between edges -> all outputs return to their reset values. Four new samples 0x3c00, 0x4000, 0x3800, 0x3c00 give a single entry of 0x4000.
- **`pool_size` change and NaN ordering:** `pool_size`=0 gives a window of 1. Changing `pool_size` mid-window affects only the next window. Samples 0x7c00 (+inf) and 0x7e00 (NaN) in a window of 2 -> 0x7e00.
